uart_receiver: RTL

Serial-to-parallel UART receiver for 8N1 frames (1 start, 8 data LSB-first, 1 stop). It is the receive-side counterpart of the board's UART transmitter and shares its bit period of 13021 clock cycles at 9600 baud. It feeds received bytes, such as weights, inputs and commands, into the accelerator's load logic. The block synchronises the asynchronous `RxD` line, validates the start bit, majority-votes each bit at mid-period, and flags framing errors.

---
 rtl/uart_receiver.sv | 79 +++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a 2-flop synchroniser, 3-sample mid-bit majority vote and framing-error detection
// Ports: clk, reset (sync, active-high), RxD (async serial in, idles high),
//        data (last good byte), rx_valid (1-cycle pulse, data already updated),
//        frame_err (1-cycle pulse, stop bit low), busy (frame in progress)
module uart_receiver #(
    parameter int CLKS_PER_BIT = 13021
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HM1 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_H = CW'(HALF);
    localparam logic [CW-1:0] C_HP1 = CW'(HALF + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_n;
    logic rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic armed, s0, s1, vote, vote_pt, last;

    assign vote_pt = cnt == C_HP1;
    assign last = cnt == C_LAST;
    assign vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = armed && !rx_s ? START : IDLE;
            START: state_n = vote_pt && vote ? IDLE : last ? DATA : START;
            DATA:  state_n = last && bit_idx == 3'd7 ? STOP : DATA;
            STOP:  state_n = vote_pt ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            armed <= 1'b0;
            s0 <= 1'b0;
            s1 <= 1'b0;
            data <= 8'h00;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m <= RxD;
            rx_s <= rx_m;
            state <= state_n;
            // cleared on every state entry and at each bit boundary; parked at 0 in IDLE
            cnt <= (state_n != state || state == IDLE || last) ? '0 : cnt + 1'b1;
            if (cnt == C_HM1) s0 <= rx_s;
            if (cnt == C_H) s1 <= rx_s;
            // arming only from a seen-high line keeps a held-low break from retriggering
            armed <= state_n == START ? 1'b0 : armed | (state == IDLE && rx_s);
            if (state == DATA && vote_pt) shreg <= {vote, shreg[7:1]};
            bit_idx <= state != DATA ? 3'd0 : last ? bit_idx + 3'd1 : bit_idx;
            rx_valid <= state == STOP && vote_pt && vote;
            frame_err <= state == STOP && vote_pt && !vote;
            if (state == STOP && vote_pt && vote) data <= shreg;
        end
    end
endmodule
